// File: rtl/systolic_drain.sv
// systolic_drain: collects result words from N1 systolic lanes and serialises
// them onto a single valid/ready output stream with destination addresses.
//
// Each lane has its own FIFO of {data, address} entries. The address is the
// lane's base offset in the M*M result matrix plus a per-lane word counter.
// A round-robin arbiter selects the lane that feeds a single output register
// stage. An accepted-word counter produces a one-cycle done pulse after every
// M*M accepted words.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   D          lane results, lane x at [x*D_W_ACC +: D_W_ACC]
//   valid_D    per-lane result strobe
//   out_ready  downstream accept
//   out_valid  out_data/out_addr hold a word
//   out_data   result word
//   out_addr   destination word address in the result matrix
//   overflow   sticky per-lane drop flag (cleared only by rst)
//   done       one-cycle pulse when the M*M-th word of a matrix is accepted
module systolic_drain #(
  parameter int D_W_ACC    = 16,
  parameter int N1         = 4,
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N1*D_W_ACC-1:0]     D,
  input  logic [N1-1:0]             valid_D,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [D_W_ACC-1:0]        out_data,
  output logic [$clog2(M*M)-1:0]    out_addr,
  output logic [N1-1:0]             overflow,
  output logic                      done
);

  localparam int WPL = (M * M) / N1;                 // words per lane per matrix
  localparam int AW  = $clog2(M * M);
  localparam int KW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = (N1 > 1) ? $clog2(N1) : 1;

  // FIFO storage and bookkeeping
  logic [D_W_ACC-1:0] mem_data [N1][FIFO_DEPTH];
  logic [AW-1:0]      mem_addr [N1][FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr   [N1];
  logic [PW-1:0]      rd_ptr   [N1];
  logic [PW:0]        count    [N1];
  logic [KW-1:0]      k        [N1];

  logic [N1-1:0] not_empty, full, push, pop, drop;
  logic [LW-1:0] grant, last_grant;
  logic          any_ne;
  logic          load, xfer;
  logic [AW-1:0] acc_cnt;

  // Output register may take a new word when empty or when its word leaves.
  assign load = !out_valid || out_ready;
  assign xfer = out_valid && out_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    not_empty = '0;
    full      = '0;
    for (int x = 0; x < N1; x++) begin
      not_empty[x] = (count[x] != '0);
      full[x]      = (count[x] == (PW+1)'(FIFO_DEPTH));
    end
  end

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    int idx;
    any_ne = 1'b0;
    grant  = '0;
    idx    = 0;
    for (int i = 1; i <= N1; i++) begin
      idx = (int'(last_grant) + i) % N1;
      if (!any_ne && not_empty[idx]) begin
        any_ne = 1'b1;
        grant  = LW'(idx);
      end
    end
  end

  // A full FIFO can still accept a word on the edge it is popped.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int x = 0; x < N1; x++) begin
      pop[x]  = load && any_ne && (grant == LW'(x));
      push[x] = valid_D[x] && (!full[x] || pop[x]);
      drop[x] = valid_D[x] && full[x] && !pop[x];
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is tracked by count, so stale
  // entries are never observed and the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    for (int x = 0; x < N1; x++) begin
      if (push[x]) begin
        mem_data[x][wr_ptr[x]] <= D[x*D_W_ACC +: D_W_ACC];
        mem_addr[x][wr_ptr[x]] <= AW'(x * WPL) + AW'(k[x]);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < N1; x++) begin
        wr_ptr[x] <= '0;
        rd_ptr[x] <= '0;
        count[x]  <= '0;
        k[x]      <= '0;
      end
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      overflow   <= '0;
      done       <= 1'b0;
      acc_cnt    <= '0;
      last_grant <= LW'(N1 - 1);
    end else begin
      for (int x = 0; x < N1; x++) begin
        if (push[x]) begin
          wr_ptr[x] <= wr_ptr[x] + 1'b1;
          k[x]      <= (k[x] == KW'(WPL - 1)) ? '0 : k[x] + 1'b1;
        end
        if (pop[x]) rd_ptr[x] <= rd_ptr[x] + 1'b1;
        case ({push[x], pop[x]})
          2'b10:   count[x] <= count[x] + 1'b1;
          2'b01:   count[x] <= count[x] - 1'b1;
          default: ;
        endcase
        if (drop[x]) overflow[x] <= 1'b1;
      end

      if (load) begin
        out_valid <= any_ne;
        if (any_ne) begin
          out_data   <= mem_data[grant][rd_ptr[grant]];
          out_addr   <= mem_addr[grant][rd_ptr[grant]];
          last_grant <= grant;
        end
      end

      done <= xfer && (acc_cnt == AW'(M * M - 1));
      if (xfer) acc_cnt <= (acc_cnt == AW'(M * M - 1)) ? '0 : acc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: directed table, multi-cycle corner
// sequences and randomized traffic compared against a queue-based model.
module tb_systolic_drain;

  localparam int DW    = 16;
  localparam int N1    = 4;
  localparam int M     = 8;
  localparam int DEPTH = 16;
  localparam int WPL   = (M * M) / N1;
  localparam int AW    = $clog2(M * M);

  logic               clk = 1'b0;
  logic               rst;
  logic [N1*DW-1:0]   D;
  logic [N1-1:0]      valid_D;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [AW-1:0]      out_addr;
  logic [N1-1:0]      overflow;
  logic               done;

  always #5 clk = ~clk;

  systolic_drain #(.D_W_ACC(DW), .N1(N1), .M(M), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .D(D), .valid_D(valid_D), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .overflow(overflow), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } entry_t;

  entry_t        mq [N1][$];
  int            mk [N1];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [N1-1:0] m_ovf;
  logic          m_done;
  int            m_acc;
  int            m_last;

  task automatic model_edge();
    bit     xfer, load;
    int     popped;
    entry_t e;
    if (rst) begin
      for (int x = 0; x < N1; x++) begin
        mq[x].delete();
        mk[x] = 0;
      end
      m_valid = 0; m_data = '0; m_addr = '0; m_ovf = '0; m_done = 0;
      m_acc = 0; m_last = N1 - 1;
    end else begin
      xfer   = m_valid && out_ready;
      load   = !m_valid || out_ready;
      m_done = 0;
      if (xfer) begin
        if (m_acc == M * M - 1) begin
          m_acc  = 0;
          m_done = 1;
        end else begin
          m_acc++;
        end
      end
      if (load) begin
        popped = -1;
        for (int i = 1; i <= N1; i++) begin
          int l;
          l = (m_last + i) % N1;
          if (popped < 0 && mq[l].size() > 0) popped = l;
        end
        if (popped >= 0) begin
          e       = mq[popped].pop_front();
          m_valid = 1;
          m_data  = e.d;
          m_addr  = e.a;
          m_last  = popped;
        end else begin
          m_valid = 0;
        end
      end
      // Room is judged after this edge's pop, so a popped full FIFO accepts.
      for (int x = 0; x < N1; x++) begin
        if (valid_D[x]) begin
          if (mq[x].size() < DEPTH) begin
            e.d = D[x*DW +: DW];
            e.a = AW'(x * WPL + mk[x]);
            mq[x].push_back(e);
            mk[x] = (mk[x] + 1) % WPL;
          end else begin
            m_ovf[x] = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- cycle step with per-cycle model comparison ----------------
  int xfers;
  int done_cnt;
  int seen [M*M];

  task automatic step();
    if (out_valid === 1'b1 && out_ready && !rst) begin
      xfers++;
      seen[out_addr]++;
    end
    @(posedge clk);
    model_edge();
    #1;
    if (done === 1'b1) done_cnt++;
    check("model out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("model out_data", out_data, m_data);
      check("model out_addr", out_addr, m_addr);
    end
    check("model overflow", overflow, m_ovf);
    check("model done", done, m_done);
  endtask

  task automatic clear_stats();
    xfers    = 0;
    done_cnt = 0;
    for (int i = 0; i < M * M; i++) seen[i] = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic             rst;
    logic [N1-1:0]    vd;
    logic [N1*DW-1:0] d;
    logic             rdy;
    logic             ev;
    logic [DW-1:0]    ed;
    logic [AW-1:0]    ea;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 4'b0000, 64'h0,                    1'b1, 1'b0, 16'h0,    6'd0};
    vecs[1]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_1234,  1'b1, 1'b0, 16'h0,    6'd0};
    vecs[2]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'h1234, 6'd0};
    vecs[3]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b0, 16'h0,    6'd0};
    vecs[4]  = '{1'b1, 4'b0000, 64'h0,                    1'b1, 1'b0, 16'h0,    6'd0};
    vecs[5]  = '{1'b0, 4'b1111, 64'h0004_0003_0002_0001,  1'b1, 1'b0, 16'h0,    6'd0};
    vecs[6]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'h1,    6'd0};
    vecs[7]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'h2,    6'd16};
    vecs[8]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'h3,    6'd32};
    vecs[9]  = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'h4,    6'd48};
    vecs[10] = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b0, 16'h0,    6'd0};
    vecs[11] = '{1'b0, 4'b0010, 64'h0000_0000_AAAA_0000,  1'b1, 1'b0, 16'h0,    6'd0};
    vecs[12] = '{1'b0, 4'b0000, 64'h0,                    1'b1, 1'b1, 16'hAAAA, 6'd17};

    rst = 1'b1; valid_D = '0; D = '0; out_ready = 1'b0;
    clear_stats();
    step();
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 16'h0);
    check("reset out_addr", out_addr, 6'd0);
    check("reset overflow", overflow, 4'b0000);
    check("reset done", done, 1'b0);

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; valid_D = vecs[i].vd; D = vecs[i].d; out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d out_data", i), out_data, vecs[i].ed);
        check($sformatf("vec%0d out_addr", i), out_addr, vecs[i].ea);
      end
    end

    // ---- backpressure: held word stays stable, nothing lost ----
    rst = 1'b1; valid_D = '0; out_ready = 1'b0; step();
    rst = 1'b0; valid_D = 4'b0010; D = 64'h0000_0000_BEEF_0000; step();
    D = 64'h0000_0000_CAFE_0000; step();
    valid_D = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold out_valid", out_valid, 1'b1);
      check("hold out_data", out_data, 16'hBEEF);
      check("hold out_addr", out_addr, 6'd16);
    end
    out_ready = 1'b1; step();
    check("drain 2nd data", out_data, 16'hCAFE);
    check("drain 2nd addr", out_addr, 6'd17);
    step();
    check("drain empty", out_valid, 1'b0);

    // ---- overflow on lane 2 ----
    rst = 1'b1; out_ready = 1'b0; step();
    rst = 1'b0; clear_stats();
    for (int i = 0; i < DEPTH + 3; i++) begin
      valid_D = 4'b0100; D = '0; D[2*DW +: DW] = DW'(i + 1);
      step();
    end
    valid_D = '0;
    check("overflow set", overflow, 4'b0100);
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) step();
    check("overflow retained words", xfers, DEPTH + 1);
    check("overflow sticky", overflow, 4'b0100);
    rst = 1'b1; step();
    check("overflow cleared by rst", overflow, 4'b0000);

    // ---- full matrix ----
    rst = 1'b1; step();
    rst = 1'b0; out_ready = 1'b1; clear_stats();
    for (int i = 0; i < WPL; i++) begin
      valid_D = 4'b1111; D = {$urandom, $urandom};
      step();
    end
    valid_D = '0;
    for (int i = 0; i < 100; i++) step();
    begin
      int once;
      once = 0;
      for (int a = 0; a < M * M; a++) if (seen[a] == 1) once++;
      check("matrix transfers", xfers, M * M);
      check("matrix addresses once", once, M * M);
      check("matrix done pulses", done_cnt, 1);
      check("matrix overflow", overflow, 4'b0000);
    end

    // ---- reset mid-matrix ----
    rst = 1'b1; step();
    rst = 1'b0; clear_stats();
    for (int i = 0; i < 40 && xfers < 10; i++) begin
      valid_D = 4'b1111; D = {$urandom, $urandom};
      step();
    end
    check("midreset accepted", xfers, 10);
    rst = 1'b1; step();
    check("midreset out_valid", out_valid, 1'b0);
    rst = 1'b0; valid_D = 4'b0001; D = 64'h0000_0000_0000_5A5A; step();
    valid_D = '0; step();
    check("midreset first valid", out_valid, 1'b1);
    check("midreset first data", out_data, 16'h5A5A);
    check("midreset first addr", out_addr, 6'd0);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      valid_D   = (i % 500 < 250) ? N1'($urandom) : N1'($urandom & $urandom & $urandom);
      D         = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
